// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and fetch defaults.
// Modules take widths as parameters; these typedefs describe the default 16-bit machine.
package cpu_pkg;

  localparam int unsigned DATA_W_DEFAULT   = 16;
  localparam int unsigned ADDR_W_DEFAULT   = 16;
  localparam int unsigned PC_INC_DEFAULT   = 2;
  localparam int unsigned RESET_PC_DEFAULT = 0;

  typedef logic [ADDR_W_DEFAULT-1:0] addr_t;
  typedef logic [DATA_W_DEFAULT-1:0] instr_t;

  typedef struct packed {
    instr_t instr;
    addr_t  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry {instr, pc} buffer; a push is visible at the head the next cycle, and the head is read combinationally.
// No internal backpressure: the caller's credit scheme guarantees no push when full; flush overrides push/pop.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop,
  input  logic                   flush,
  output logic [W-1:0]           head_dat,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_pop;

  assign do_pop   = pop & (count != '0);
  assign head_dat = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      mem    <= '{default: '0};
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, pipelined imem requests, return buffer; a response reaches out_valid one cycle later.
// Requests are credit-limited so outstanding + buffered never exceeds DEPTH; out_ready low stalls issue once credits run out.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned        DATA_W   = DATA_W_DEFAULT,
  parameter int unsigned        ADDR_W   = ADDR_W_DEFAULT,
  parameter int unsigned        DEPTH    = 4,
  parameter int unsigned        PC_INC   = PC_INC_DEFAULT,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              hlt,
  output logic [ADDR_W-1:0] pc
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = CW + 1;

  logic [ADDR_W-1:0]        fetch_pc;
  logic [ADDR_W-1:0]        resp_pc;
  logic [CW-1:0]            outstanding;
  logic [CW-1:0]            outstanding_nxt;
  logic [CW-1:0]            drop_cnt;
  logic [CW-1:0]            count;
  logic                     halted;
  logic [SW-1:0]            credit_used;
  logic                     accept;
  logic                     flush;
  logic                     push;
  logic                     pop;
  logic [DATA_W+ADDR_W-1:0] head_dat;

  assign credit_used = {1'b0, outstanding} + {1'b0, count};

  // Gated by rst_n so no request is presented while the memory is held in reset.
  assign imem_req  = rst_n & ~halted & (credit_used < SW'(DEPTH));
  assign accept    = imem_req & imem_gnt;
  assign flush     = redirect | halt;
  assign push      = imem_rvalid & (drop_cnt == '0) & ~flush;
  assign pop       = out_valid & out_ready;

  assign outstanding_nxt = outstanding + CW'(accept) - CW'(imem_rvalid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      halted      <= 1'b0;
    end else begin
      outstanding <= outstanding_nxt;
      if (halt) begin
        halted <= 1'b1;
      end
      if (redirect) begin
        fetch_pc <= redirect_pc;
      end else if (accept) begin
        fetch_pc <= fetch_pc + ADDR_W'(PC_INC);
      end
      // Everything still in flight after a flush, including this cycle's accept, is stale.
      if (flush) begin
        drop_cnt <= outstanding_nxt;
        resp_pc  <= redirect ? redirect_pc : fetch_pc;
      end else begin
        if (imem_rvalid && (drop_cnt != '0)) begin
          drop_cnt <= drop_cnt - CW'(1);
        end
        if (push) begin
          resp_pc <= resp_pc + ADDR_W'(PC_INC);
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (DATA_W + ADDR_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat ({imem_rdata, resp_pc}),
    .pop      (pop),
    .flush    (flush),
    .head_dat (head_dat),
    .count    (count)
  );

  assign out_valid = (count != '0);
  assign out_instr = head_dat[DATA_W+ADDR_W-1:ADDR_W];
  assign out_pc    = head_dat[ADDR_W-1:0];
  assign hlt       = halted & (outstanding == '0);
  assign imem_addr = fetch_pc;
  assign pc        = fetch_pc;

endmodule
